// File: rtl/alu_exec_ctrl.sv
// EX-stage ALU: decodes ALUOp/funct, executes single-cycle ops in one cycle and
// runs signed MULT/DIV iteratively into HI/LO, with valid/ready on both sides.
module alu_exec_ctrl #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH),
  parameter int unsigned CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_op,
  input  logic [5:0]         funct,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               branch_taken,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               illegal,
  output logic               div_zero,
  output logic               busy
);
  localparam int unsigned MSB = WIDTH - 1;
  localparam int unsigned W2  = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  typedef enum logic [3:0] {
    C_ADD  = 4'd0,  C_SUB = 4'd1, C_AND = 4'd2, C_OR  = 4'd3,
    C_SLT  = 4'd4,  C_SLL = 4'd5, C_MUL = 4'd6, C_DIV = 4'd7,
    C_NE   = 4'd8,  C_GTZ = 4'd9, C_JMP = 4'd10, C_BEQ = 4'd11,
    C_ILL  = 4'd15
  } code_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   opnd;
  logic               neg_lo;
  logic               neg_hi;
  logic               fix_div;
  logic               fix_dz;

  code_t              code;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   op_res;
  logic               op_br;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [W2-1:0]      prod_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign busy     = (state != IDLE);

  // ALUOp / funct decode; beq gets its own code so only it drives branch_taken on equality
  always_comb begin
    code = C_ILL;
    case (alu_op)
      4'b0000, 4'b0100, 4'b0101: code = C_ADD;
      4'b0010: code = C_OR;
      4'b0011: code = C_AND;
      4'b0110: code = C_SLT;
      4'b0111: code = C_BEQ;
      4'b1000: code = C_NE;
      4'b1001: code = C_GTZ;
      4'b0001: begin
        case (funct)
          6'b100000: code = C_ADD;
          6'b100010: code = C_SUB;
          6'b100100: code = C_AND;
          6'b100101: code = C_OR;
          6'b101010: code = C_SLT;
          6'b000000: code = C_SLL;
          6'b011000: code = C_MUL;
          6'b011010: code = C_DIV;
          6'b000010: code = C_JMP;
          default:   code = C_ILL;
        endcase
      end
      default: code = C_ILL;
    endcase
  end

  assign diff = src_a - src_b;

  always_comb begin
    op_res = '0;
    op_br  = 1'b0;
    case (code)
      C_ADD: op_res = src_a + src_b;
      C_SUB: op_res = diff;
      C_AND: op_res = src_a & src_b;
      C_OR:  op_res = src_a | src_b;
      C_SLT: op_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      C_SLL: op_res = src_b << shamt;
      C_BEQ: begin
        op_res = diff;
        op_br  = (src_a == src_b);
      end
      C_NE: begin
        op_res = diff;
        op_br  = (src_a != src_b);
      end
      C_GTZ: begin
        op_res = src_a;
        op_br  = !src_a[MSB] && (src_a != '0);
      end
      default: op_res = '0;
    endcase
  end

  // Unsigned magnitudes; the most-negative value maps to 2^(WIDTH-1), which still fits
  assign mag_a = src_a[MSB] ? (~src_a + WIDTH'(1)) : src_a;
  assign mag_b = src_b[MSB] ? (~src_b + WIDTH'(1)) : src_b;

  // Shift-add step for MUL and restoring trial subtract for DIV
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : (WIDTH+1)'(0));
  assign div_trial = {acc_hi, acc_lo[MSB]} - {1'b0, opnd};

  // Sign correction applied in FIX
  always_comb begin
    prod_fix = neg_lo ? (~{acc_hi, acc_lo} + W2'(1)) : {acc_hi, acc_lo};
    fix_hi   = prod_fix[W2-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (fix_dz) begin
      fix_hi = acc_hi;
      fix_lo = acc_lo;
    end else if (fix_div) begin
      fix_lo = neg_lo ? (~acc_lo + WIDTH'(1)) : acc_lo;
      fix_hi = neg_hi ? (~acc_hi + WIDTH'(1)) : acc_hi;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      acc_hi       <= '0;
      acc_lo       <= '0;
      opnd         <= '0;
      neg_lo       <= 1'b0;
      neg_hi       <= 1'b0;
      fix_div      <= 1'b0;
      fix_dz       <= 1'b0;
      out_valid    <= 1'b0;
      result       <= '0;
      zero         <= 1'b0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
      div_zero     <= 1'b0;
      hi           <= '0;
      lo           <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            fix_div <= (code == C_DIV);
            fix_dz  <= 1'b0;
            cnt     <= CNT_W'(WIDTH);
            neg_lo  <= src_a[MSB] ^ src_b[MSB];
            neg_hi  <= src_a[MSB];
            case (code)
              C_MUL: begin
                state  <= MUL;
                acc_hi <= '0;
                acc_lo <= mag_b;
                opnd   <= mag_a;
              end
              C_DIV: begin
                if (src_b == '0) begin
                  state  <= FIX;
                  fix_dz <= 1'b1;
                  acc_hi <= src_a;
                  acc_lo <= '1;
                end else begin
                  state  <= DIV;
                  acc_hi <= '0;
                  acc_lo <= mag_a;
                  opnd   <= mag_b;
                end
              end
              default: begin
                out_valid    <= 1'b1;
                result       <= op_res;
                zero         <= (op_res == '0);
                branch_taken <= op_br;
                illegal      <= (code == C_ILL);
                div_zero     <= 1'b0;
              end
            endcase
          end
        end
        MUL: begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[MSB:1]};
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        DIV: begin
          if (!div_trial[WIDTH]) begin
            acc_hi <= div_trial[WIDTH-1:0];
            acc_lo <= {acc_lo[MSB-1:0], 1'b1};
          end else begin
            acc_hi <= {acc_hi[MSB-1:0], acc_lo[MSB]};
            acc_lo <= {acc_lo[MSB-1:0], 1'b0};
          end
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          // Completion waits until the output slot is free
          if (!out_valid || out_ready) begin
            hi           <= fix_hi;
            lo           <= fix_lo;
            result       <= fix_lo;
            zero         <= (fix_lo == '0);
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
            div_zero     <= fix_dz;
            out_valid    <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: arithmetic reference model plus per-cycle output checker,
// with directed vectors carrying hand-computed literals.
module tb_alu_exec_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        branch_taken;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        illegal;
  logic        div_zero;
  logic        busy;

  alu_exec_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .shamt(shamt), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
    .branch_taken(branch_taken), .hi(hi), .lo(lo), .illegal(illegal),
    .div_zero(div_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        br;
    logic        ill;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_hi, m_lo;   // HI/LO after the last issued op
  logic [31:0] c_hi, c_lo;   // HI/LO after the last consumed result
  int          n_cmp = 0;
  int          n_bad = 0;
  int          k, stall, hold_bad;
  time         t0;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endfunction

  // Reference: instruction semantics with 64-bit signed arithmetic
  function automatic void model(input logic [3:0] op, input logic [5:0] fn, input logic [4:0] sh,
                                input logic [31:0] a, input logic [31:0] b, output exp_t e);
    longint sa, sb, p, qq, rr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e = '0;
    e.hi = m_hi;
    e.lo = m_lo;
    case (op)
      4'b0000, 4'b0100, 4'b0101: e.res = a + b;
      4'b0010: e.res = a | b;
      4'b0011: e.res = a & b;
      4'b0110: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'b0111: begin e.res = a - b; e.br = (a == b); end
      4'b1000: begin e.res = a - b; e.br = (a != b); end
      4'b1001: begin e.res = a; e.br = (sa > 0); end
      4'b0001: begin
        case (fn)
          6'b100000: e.res = a + b;
          6'b100010: e.res = a - b;
          6'b100100: e.res = a & b;
          6'b100101: e.res = a | b;
          6'b101010: e.res = (sa < sb) ? 32'd1 : 32'd0;
          6'b000000: e.res = b << sh;
          6'b011000: begin
            p = sa * sb;
            e.hi = p[63:32]; e.lo = p[31:0]; e.res = e.lo;
          end
          6'b011010: begin
            if (b == 32'd0) begin
              e.hi = a; e.lo = 32'hFFFF_FFFF; e.res = e.lo; e.dz = 1'b1;
            end else begin
              qq = sa / sb; rr = sa % sb;
              e.lo = qq[31:0]; e.hi = rr[31:0]; e.res = e.lo;
            end
          end
          6'b000010: e.res = 32'd0;
          default:   e.ill = 1'b1;
        endcase
      end
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.res == 32'd0);
    m_hi = e.hi;
    m_lo = e.lo;
  endfunction

  // Per-cycle checker: held result against the queue head, HI/LO otherwise
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 128'(out_valid), 128'(0));
        end else begin
          chk("out", {result, zero, branch_taken, illegal, div_zero, hi, lo}, q[0]);
          if (out_ready) begin
            c_hi = q[0].hi;
            c_lo = q[0].lo;
            void'(q.pop_front());
          end
        end
      end else begin
        chk("hilo_idle", {hi, lo}, {c_hi, c_lo});
      end
    end
  end

  task automatic clear_model();
    q.delete();
    m_hi = '0; m_lo = '0; c_hi = '0; c_lo = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [5:0] fn, input logic [4:0] sh,
                      input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    in_valid = 1'b1; alu_op = op; funct = fn; shamt = sh; src_a = a; src_b = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        model(op, fn, sh, a, b, e);
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    chk("accept_timeout", 128'(in_ready), 128'(1));
    in_valid = 1'b0;
  endtask

  // Returns at the negedge where out_valid is seen; lat = edges after the accept edge
  task automatic wait_out(output int lat, output int stall_bad);
    lat = 0;
    stall_bad = 0;
    while (1) begin
      @(negedge clk);
      if (out_valid) return;
      if (in_ready !== 1'b0 || busy !== 1'b1) stall_bad++;
      lat++;
      if (lat > 100) begin
        chk("out_valid_timeout", 128'(out_valid), 128'(1));
        return;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; alu_op = '0; funct = '0; shamt = '0;
    src_a = '0; src_b = '0; out_ready = 1'b1;
    clear_model();
    step();
    clear_model();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_state", {out_valid, in_ready, busy, result, hi, lo}, {1'b0, 1'b1, 1'b0, 96'h0});
    step();

    // T1: R-type add
    send(4'b0001, 6'b100000, 5'd0, 32'd5, 32'd7);
    wait_out(k, stall);
    chk("t1_lat", 128'(k), 128'(0));
    chk("t1_add", {result, zero, illegal}, {32'd12, 1'b0, 1'b0});
    step();

    // T2: branches
    send(4'b0111, 6'd0, 5'd0, 32'h1234, 32'h1234);
    wait_out(k, stall);
    chk("t2_beq", {result, zero, branch_taken}, {32'd0, 1'b1, 1'b1});
    step();
    send(4'b1001, 6'd0, 5'd0, 32'h8000_0000, 32'd0);
    wait_out(k, stall);
    chk("t2_bgtz_neg", {result, branch_taken}, {32'h8000_0000, 1'b0});
    step();
    send(4'b1000, 6'd0, 5'd0, 32'd3, 32'd4);
    wait_out(k, stall);
    chk("t2_bne", {result, branch_taken}, {32'hFFFF_FFFF, 1'b1});
    step();

    // Back-to-back single-cycle ops, one accepted per cycle
    t0 = $time;
    send(4'b0000, 6'd0,       5'd0, 32'hFFFF_FFFF, 32'd1);
    send(4'b0100, 6'd0,       5'd0, 32'h1000, 32'h24);
    send(4'b0101, 6'd0,       5'd0, 32'h7FFF_FFFF, 32'd1);
    send(4'b0010, 6'd0,       5'd0, 32'hF0F0, 32'h0F0F);
    send(4'b0011, 6'd0,       5'd0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    send(4'b0110, 6'd0,       5'd0, 32'hFFFF_FFFE, 32'd3);
    send(4'b0110, 6'd0,       5'd0, 32'd5, 32'hFFFF_FFFF);
    send(4'b0001, 6'b100010,  5'd0, 32'd3, 32'd5);
    send(4'b0001, 6'b100100,  5'd0, 32'hC3C3_C3C3, 32'h0FF0_F00F);
    send(4'b0001, 6'b100101,  5'd0, 32'h1200_0034, 32'h0056_7800);
    send(4'b0001, 6'b101010,  5'd0, 32'h8000_0000, 32'd1);
    send(4'b0001, 6'b000000,  5'd4, 32'd0, 32'h0F00_000F);
    send(4'b0001, 6'b000010,  5'd0, 32'd1, 32'd2);
    send(4'b0001, 6'b111111,  5'd0, 32'd1, 32'd2);
    send(4'b1001, 6'd0,       5'd0, 32'd5, 32'd0);
    send(4'b1000, 6'd0,       5'd0, 32'd7, 32'd7);
    chk("thru_cycles", 128'(($time - t0) / 10), 128'(16));
    repeat (2) step();

    // T3: MULT
    send(4'b0001, 6'b011000, 5'd0, 32'hFFFF_FFFD, 32'd7);
    wait_out(k, stall);
    chk("t3_lat", 128'(k), 128'(33));
    chk("t3_busy_stall", 128'(stall), 128'(0));
    chk("t3_mult", {hi, lo, result}, {32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'hFFFF_FFEB});
    step();
    send(4'b0001, 6'b011000, 5'd0, 32'h8000_0000, 32'h8000_0000);
    wait_out(k, stall);
    chk("t3_mult_min", {hi, lo, zero}, {32'h4000_0000, 32'h0, 1'b1});
    step();
    send(4'b0001, 6'b011000, 5'd0, 32'h7FFF_FFFF, 32'h8000_0000);
    wait_out(k, stall);
    step();

    // T4: DIV
    send(4'b0001, 6'b011010, 5'd0, 32'hFFFF_FFF9, 32'd2);
    wait_out(k, stall);
    chk("t4_lat", 128'(k), 128'(33));
    chk("t4_div", {lo, hi, div_zero}, {32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0});
    step();
    send(4'b0001, 6'b011010, 5'd0, 32'd9, 32'd0);
    wait_out(k, stall);
    chk("t4_dz_lat", 128'(k), 128'(1));
    chk("t4_dz", {div_zero, hi, lo}, {1'b1, 32'd9, 32'hFFFF_FFFF});
    step();
    send(4'b0001, 6'b011010, 5'd0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_out(k, stall);
    chk("t4_min_neg1", {lo, hi, div_zero}, {32'h8000_0000, 32'h0, 1'b0});
    step();
    send(4'b0001, 6'b011010, 5'd0, 32'd100, 32'hFFFF_FFF9);
    wait_out(k, stall);
    chk("t4_div_100", {lo, hi}, {32'hFFFF_FFF2, 32'd2});
    step();

    // T5: backpressure then same-cycle accept
    out_ready = 1'b0;
    send(4'b0001, 6'b100000, 5'd0, 32'd1, 32'd2);
    wait_out(k, stall);
    hold_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!(out_valid === 1'b1 && result === 32'd3 && in_ready === 1'b0)) hold_bad++;
    end
    chk("t5_hold", 128'(hold_bad), 128'(0));
    step();
    out_ready = 1'b1;
    t0 = $time;
    send(4'b0001, 6'b100000, 5'd0, 32'd10, 32'd20);
    chk("t5_accept_cycles", 128'(($time - t0) / 10), 128'(1));
    wait_out(k, stall);
    chk("t5_new", {128'(k), result}, {128'(0), 32'd30});
    step();

    // T6: illegal alu_op keeps HI/LO, then reset mid-MULT
    send(4'b1011, 6'd0, 5'd0, 32'd1, 32'd2);
    wait_out(k, stall);
    chk("t6_illegal", {result, illegal, zero, hi, lo}, {32'd0, 1'b1, 1'b1, 32'd2, 32'hFFFF_FFF2});
    step();
    send(4'b0001, 6'b011000, 5'd0, 32'h1234_5678, 32'h10);
    repeat (10) step();
    rst_n = 1'b0;
    step();
    chk("t6_rst", {out_valid, busy, in_ready, hi, lo}, {1'b0, 1'b0, 1'b1, 64'h0});
    clear_model();
    rst_n = 1'b1;
    step();
    send(4'b0000, 6'd0, 5'd0, 32'd1, 32'd1);
    wait_out(k, stall);
    chk("t6_after_rst", {result, hi, lo}, {32'd2, 64'h0});
    repeat (3) step();
    chk("queue_drained", 128'(q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
